// File: rtl/merge_stream16_pkg.sv
// Shared definitions for the two-way sorted-run merger: data width, FSM states
// and the merge direction encoding.
package merge_stream16_pkg;

  localparam int DATA_W = 16;

  localparam logic ASCENDING  = 1'b1;
  localparam logic DESCENDING = 1'b0;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } state_e;

endpackage

// File: rtl/merge_select16.sv
// Unsigned head-of-run compare; ties favour A so the merge stays stable.
module merge_select16
  import merge_stream16_pkg::*;
#(
  parameter logic DIR = ASCENDING
) (
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              sel_a
);

  always_comb begin
    if (DIR == ASCENDING) sel_a = (a_data <= b_data);
    else                  sel_a = (a_data >= b_data);
  end

endmodule

// File: rtl/merge_stream16.sv
// Merges one sorted run from A and one from B into a single sorted run,
// one element per cycle through a registered valid/ready output stage.
module merge_stream16
  import merge_stream16_pkg::*;
#(
  parameter logic DIR   = ASCENDING,
  parameter int   CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  input  logic              a_last,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  input  logic              b_last,
  output logic              b_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  run_count
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, last_q, last_d;
  logic [CNT_W-1:0]    run_count_q;
  logic                advance, load, sel_a;

  merge_select16 #(.DIR(DIR)) u_select (
    .a_data (a_data),
    .b_data (b_data),
    .sel_a  (sel_a)
  );

  assign advance = !valid_q || out_ready;

  always_comb begin
    state_d = state_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    load    = 1'b0;
    data_d  = data_q;
    last_d  = last_q;
    // Ready is gated by rst so nothing is acknowledged while the block is held.
    if (!rst && advance) begin
      unique case (state_q)
        MERGE: begin
          if (a_valid && b_valid) begin
            load   = 1'b1;
            last_d = 1'b0;
            if (sel_a) begin
              a_ready = 1'b1;
              data_d  = a_data;
              if (a_last) state_d = DRAIN_B;
            end else begin
              b_ready = 1'b1;
              data_d  = b_data;
              if (b_last) state_d = DRAIN_A;
            end
          end
        end
        DRAIN_A: begin
          if (a_valid) begin
            load    = 1'b1;
            a_ready = 1'b1;
            data_d  = a_data;
            last_d  = a_last;
            if (a_last) state_d = MERGE;
          end
        end
        DRAIN_B: begin
          if (b_valid) begin
            load    = 1'b1;
            b_ready = 1'b1;
            data_d  = b_data;
            last_d  = b_last;
            if (b_last) state_d = MERGE;
          end
        end
        default: state_d = MERGE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MERGE;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      run_count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      if (load)           valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (valid_q && out_ready && last_q) run_count_q <= run_count_q + CNT_W'(1);
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign run_count = run_count_q;

endmodule

// File: tb/tb_merge_stream16.sv
// Scoreboard bench: an ascending and a descending merger fed from source queues,
// with a monitor popping expected {last,data} pairs on every output handshake.
module tb_merge_stream16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_ready = 1'b1;
  logic        bp_en = 1'b0;

  logic [15:0] a_data = '0, b_data = '0, c_data = '0, d_data = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0, d_valid = 1'b0;
  logic        a_last = 1'b0, b_last = 1'b0, c_last = 1'b0, d_last = 1'b0;
  logic        a_ready, b_ready, c_ready, d_ready;
  logic [15:0] o_data0, o_data1;
  logic        o_valid0, o_valid1, o_last0, o_last1;
  logic [15:0] rc0, rc1;

  logic [16:0] qa[$], qb[$], qc[$], qd[$];
  logic [16:0] ea[$], ed[$];
  int          acc_port[$], acc_cyc[$];
  int          cyc = 0;
  int          mon_cnt0 = 0;
  int          n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  merge_stream16 #(.DIR(1'b1), .CNT_W(16)) dut_asc (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .out_data(o_data0), .out_valid(o_valid0), .out_last(o_last0),
    .out_ready(out_ready), .run_count(rc0)
  );

  merge_stream16 #(.DIR(1'b0), .CNT_W(16)) dut_dsc (
    .clk(clk), .rst(rst),
    .a_data(c_data), .a_valid(c_valid), .a_last(c_last), .a_ready(c_ready),
    .b_data(d_data), .b_valid(d_valid), .b_last(d_last), .b_ready(d_ready),
    .out_data(o_data1), .out_valid(o_valid1), .out_last(o_last1),
    .out_ready(out_ready), .run_count(rc1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Source driver: present queue heads after the falling edge, pop on handshake.
  initial begin
    logic fa, fb, fc, fd;
    forever begin
      @(negedge clk);
      a_valid = !rst && qa.size() > 0; if (qa.size() > 0) {a_last, a_data} = qa[0];
      b_valid = !rst && qb.size() > 0; if (qb.size() > 0) {b_last, b_data} = qb[0];
      c_valid = !rst && qc.size() > 0; if (qc.size() > 0) {c_last, c_data} = qc[0];
      d_valid = !rst && qd.size() > 0; if (qd.size() > 0) {d_last, d_data} = qd[0];
      out_ready = bp_en ? ~out_ready : 1'b1;
      #3;
      fa = a_valid && a_ready; fb = b_valid && b_ready;
      fc = c_valid && c_ready; fd = d_valid && d_ready;
      @(posedge clk);
      cyc++;
      if (fa) begin void'(qa.pop_front()); acc_port.push_back(0); acc_cyc.push_back(cyc); end
      if (fb) begin void'(qb.pop_front()); acc_port.push_back(1); acc_cyc.push_back(cyc); end
      if (fc) void'(qc.pop_front());
      if (fd) void'(qd.pop_front());
    end
  end

  // Output monitor: scoreboard pops plus hold-during-stall checks.
  initial begin
    logic        stall0 = 1'b0, stall1 = 1'b0;
    logic [16:0] held0 = '0, held1 = '0, exp;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        stall0 = 1'b0; stall1 = 1'b0;
      end else begin
        if (stall0) check("asc_hold", {15'd0, o_valid0, o_last0, o_data0}, {15'd0, 1'b1, held0});
        if (o_valid0 && out_ready) begin
          if (ea.size() == 0) check("asc_unexpected_out", {15'd0, o_last0, o_data0}, 32'hFFFF_FFFF);
          else begin
            exp = ea.pop_front();
            check("asc_out", {15'd0, o_last0, o_data0}, {15'd0, exp});
            mon_cnt0++;
          end
        end
        stall0 = o_valid0 && !out_ready; held0 = {o_last0, o_data0};
        if (stall1) check("dsc_hold", {15'd0, o_valid1, o_last1, o_data1}, {15'd0, 1'b1, held1});
        if (o_valid1 && out_ready) begin
          if (ed.size() == 0) check("dsc_unexpected_out", {15'd0, o_last1, o_data1}, 32'hFFFF_FFFF);
          else begin
            exp = ed.pop_front();
            check("dsc_out", {15'd0, o_last1, o_data1}, {15'd0, exp});
          end
        end
        stall1 = o_valid1 && !out_ready; held1 = {o_last1, o_data1};
      end
    end
  end

  task automatic load_case1();
    qa.push_back({1'b0, 16'd1}); qa.push_back({1'b0, 16'd4}); qa.push_back({1'b1, 16'd9});
    qb.push_back({1'b0, 16'd2}); qb.push_back({1'b0, 16'd3}); qb.push_back({1'b1, 16'd10});
    ea.push_back({1'b0, 16'd1}); ea.push_back({1'b0, 16'd2}); ea.push_back({1'b0, 16'd3});
    ea.push_back({1'b0, 16'd4}); ea.push_back({1'b0, 16'd9}); ea.push_back({1'b1, 16'd10});
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, o_valid0}, 32'd0);
    check("rst_out_data", {16'd0, o_data0}, 32'd0);
    check("rst_out_last", {31'd0, o_last0}, 32'd0);
    check("rst_run_count", {16'd0, rc0}, 32'd0);
    rst = 1'b0;

    // Basic ascending merge, with a descending merge in parallel.
    load_case1();
    qc.push_back({1'b0, 16'd9}); qc.push_back({1'b1, 16'd2});
    qd.push_back({1'b1, 16'd7});
    ed.push_back({1'b0, 16'd9}); ed.push_back({1'b0, 16'd7}); ed.push_back({1'b1, 16'd2});
    repeat (7) @(posedge clk);
    #1;
    check("case1_pending", ea.size(), 32'd0);
    check("case1_run_count", {16'd0, rc0}, 32'd1);
    check("dsc_pending", ed.size(), 32'd0);
    check("dsc_run_count", {16'd0, rc1}, 32'd1);

    // Ties: A, A, B on consecutive cycles.
    acc_port.delete(); acc_cyc.delete();
    qa.push_back({1'b0, 16'd5}); qa.push_back({1'b1, 16'd5});
    qb.push_back({1'b1, 16'd5});
    ea.push_back({1'b0, 16'd5}); ea.push_back({1'b0, 16'd5}); ea.push_back({1'b1, 16'd5});
    repeat (4) @(posedge clk);
    #1;
    check("tie_run_count", {16'd0, rc0}, 32'd2);
    check("tie_accepts", acc_port.size(), 32'd3);
    if (acc_port.size() == 3) begin
      check("tie_order0", acc_port[0], 32'd0);
      check("tie_order1", acc_port[1], 32'd0);
      check("tie_order2", acc_port[2], 32'd1);
      check("tie_gap01", acc_cyc[1] - acc_cyc[0], 32'd1);
      check("tie_gap12", acc_cyc[2] - acc_cyc[1], 32'd1);
    end

    // Backpressure: out_ready toggles every cycle.
    acc_port.delete(); acc_cyc.delete();
    bp_en = 1'b1;
    load_case1();
    for (int i = 0; i < 40 && (ea.size() > 0 || qa.size() > 0 || qb.size() > 0 || o_valid0); i++) begin
      @(posedge clk);
      #1;
    end
    bp_en = 1'b0;
    check("bp_pending", ea.size(), 32'd0);
    check("bp_accepts", acc_port.size(), 32'd6);
    check("bp_run_count", {16'd0, rc0}, 32'd3);

    // Starvation: A valid, B absent.
    @(posedge clk);
    #1;
    qa.push_back({1'b1, 16'd6});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      check("starve_a_ready", {31'd0, a_ready}, 32'd0);
      check("starve_out_valid", {31'd0, o_valid0}, 32'd0);
    end
    ea.push_back({1'b0, 16'd6}); ea.push_back({1'b1, 16'd8});
    qb.push_back({1'b1, 16'd8});
    for (int i = 0; i < 10 && ea.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("starve_pending", ea.size(), 32'd0);
    check("starve_run_count", {16'd0, rc0}, 32'd4);

    // Reset after two outputs of a run.
    load_case1();
    base = mon_cnt0;
    for (int i = 0; i < 20 && mon_cnt0 < base + 2; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_outputs", mon_cnt0 - base, 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, o_valid0}, 32'd0);
    check("midrst_run_count", {16'd0, rc0}, 32'd0);
    check("midrst_a_ready", {31'd0, a_ready}, 32'd0);
    check("midrst_b_ready", {31'd0, b_ready}, 32'd0);
    qa.delete(); qb.delete(); ea.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.push_back({1'b1, 16'd3});
    qb.push_back({1'b0, 16'd1}); qb.push_back({1'b1, 16'd2});
    ea.push_back({1'b0, 16'd1}); ea.push_back({1'b0, 16'd2}); ea.push_back({1'b1, 16'd3});
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_pending", ea.size(), 32'd0);
    check("post_rst_run_count", {16'd0, rc0}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, got %0d checks, expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
